// File: rtl/dice_traffic_ctrl.sv
// Dice counter and UK-sequence traffic light running side by side; result
// shows the engine picked by sel, registered with the post-edge state.
module dice_traffic_ctrl #(
  parameter int unsigned FACES       = 6,
  parameter int unsigned T_RED       = 4,
  parameter int unsigned T_RED_AMBER = 1,
  parameter int unsigned T_GREEN     = 4,
  parameter int unsigned T_AMBER     = 1,
  localparam int unsigned OUT_W = ($clog2(FACES + 1) > 3) ? $clog2(FACES + 1) : 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             sel,
  output logic [OUT_W-1:0] result
);

  if (FACES < 2 || FACES > 255) begin : g_bad_faces
    $error("FACES must be in 2..255");
  end
  if (T_RED == 0 || T_RED_AMBER == 0 || T_GREEN == 0 || T_AMBER == 0) begin : g_bad_tmin
    $error("all T_* must be >= 1");
  end
  if (T_RED > 255 || T_RED_AMBER > 255 || T_GREEN > 255 || T_AMBER > 255) begin : g_bad_tmax
    $error("all T_* must be <= 255");
  end

  typedef enum logic [2:0] {
    TL_RED       = 3'b100,
    TL_RED_AMBER = 3'b110,
    TL_GREEN     = 3'b001,
    TL_AMBER     = 3'b010
  } tl_e;

  localparam logic [OUT_W-1:0] FACES_W = OUT_W'(FACES);

  logic [1:0]       sync_q;
  logic [OUT_W-1:0] dval_q, dval_d;
  tl_e              tl_q, tl_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             en_c, started_c;
  logic [7:0]       lim_c;

  function automatic logic [7:0] dwell_lim(input tl_e s);
    case (s)
      TL_RED:       return 8'(T_RED - 1);
      TL_RED_AMBER: return 8'(T_RED_AMBER - 1);
      TL_GREEN:     return 8'(T_GREEN - 1);
      TL_AMBER:     return 8'(T_AMBER - 1);
      default:      return 8'd0;
    endcase
  endfunction

  function automatic tl_e tl_succ(input tl_e s);
    case (s)
      TL_RED:       return TL_RED_AMBER;
      TL_RED_AMBER: return TL_GREEN;
      TL_GREEN:     return TL_AMBER;
      default:      return TL_RED;
    endcase
  endfunction

  // Stage 0 opens the update gate on the 2nd edge after release; stage 1
  // marks that first update as RED entry so RED keeps its full dwell.
  assign en_c      = sync_q[0];
  assign started_c = sync_q[1];
  assign lim_c     = dwell_lim(tl_q);

  always_comb begin
    dval_d = dval_q;
    if (button) begin
      if (dval_q == '0 || dval_q >= FACES_W) dval_d = OUT_W'(1);
      else                                   dval_d = dval_q + OUT_W'(1);
    end else if (dval_q > FACES_W) begin
      dval_d = OUT_W'(1);
    end
  end

  always_comb begin
    tl_d    = tl_q;
    dwell_d = dwell_q;
    case (tl_q)
      TL_RED, TL_RED_AMBER, TL_GREEN, TL_AMBER: begin
        if (dwell_q == lim_c) begin
          tl_d    = tl_succ(tl_q);
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: begin
        tl_d    = TL_RED;
        dwell_d = '0;
      end
    endcase
    if (!started_c) begin
      tl_d    = TL_RED;
      dwell_d = '0;
    end
  end

  assign result_d = sel ? OUT_W'(tl_d) : dval_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= 2'b00;
      dval_q   <= '0;
      tl_q     <= TL_RED;
      dwell_q  <= '0;
      result_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (en_c) begin
        dval_q   <= dval_d;
        tl_q     <= tl_d;
        dwell_q  <= dwell_d;
        result_q <= result_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_dice_traffic_ctrl.sv
// Scoreboard bench: default build (A) and FACES=12/T_GREEN=2 build (B) share stimulus.
module tb_dice_traffic_ctrl;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] res_a;
  logic [3:0] res_b;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Per-cycle traffic encodings counted from the first update edge.
  int tab_a[10] = '{4, 4, 4, 4, 6, 1, 1, 1, 1, 2};
  int tab_b[8]  = '{4, 4, 4, 4, 6, 1, 1, 2};

  always #5 clk = ~clk;

  dice_traffic_ctrl dut_a (
    .clk(clk), .rst(rst), .button(button), .sel(sel), .result(res_a)
  );

  dice_traffic_ctrl #(.FACES(12), .T_GREEN(2)) dut_b (
    .clk(clk), .rst(rst), .button(button), .sel(sel), .result(res_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic s, input string tag,
                      input int ea, input int eb);
    @(negedge clk);
    button = b;
    sel    = s;
    if (ea >= 0) qa.push_back('{tag, ea});
    if (eb >= 0) qb.push_back('{tag, eb});
  endtask

  // Drop reset between edges, hold it with busy inputs, release, expect a dead sync edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst    = 1'b0;
    button = 1'b1;
    sel    = 1'b1;
    #1;
    check("A async_rst", int'(res_a), 0);
    check("B async_rst", int'(res_b), 0);
    repeat (2) @(posedge clk);
    #2;
    check("A rst_hold", int'(res_a), 0);
    check("B rst_hold", int'(res_b), 0);
    @(negedge clk);
    rst    = 1'b1;
    button = 1'b0;
    sel    = 1'b0;
    qa.push_back('{"sync_edge", 0});
    qb.push_back('{"sync_edge", 0});
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check({"A ", e.tag}, int'(res_a), e.val);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check({"B ", e.tag}, int'(res_b), e.val);
    end
  end

  initial begin
    // Dice advance, wrap past FACES, then hold
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "dice_adv", (i % 6) + 1, i + 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "dice_hold", 2, 8);

    // Two full traffic periods on A; B runs its 8-cycle period
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "traffic", tab_a[i % 10], tab_b[i % 8]);

    // Switch to lights mid-run, back to dice, then button with sel 1->0 at dval 6
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "conc_dice", i + 1, i + 1);
    step(1'b1, 1'b1, "conc_sel", 6, 6);
    step(1'b0, 1'b0, "conc_back", 5, 5);
    step(1'b1, 1'b0, "dice_six", 6, 6);
    step(1'b0, 1'b1, "green", tab_a[7], tab_b[7]);
    step(1'b1, 1'b0, "simul", 1, 7);

    // Reset mid-GREEN, then RED must be held for its full length again
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "pre_green", tab_a[i], tab_b[i]);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "post_rst", tab_a[i], tab_b[i]);

    // B dice wraps 12 -> 1, then lights with bit 3 clear
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, "wrap", (i % 6) + 1, (i % 12) + 1);
    for (int i = 14; i < 22; i++) step(1'b0, 1'b1, "b_traffic", tab_a[i % 10], tab_b[i % 8]);

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dice_traffic_ctrl.md
DICE_TRAFFIC_CTRL -- requirements
Module: dice_traffic_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- FACES, 6, dice face count; legal range 2..255.
- T_RED, 4, cycles held in RED.
- T_RED_AMBER, 1, cycles held in RED_AMBER.
- T_GREEN, 4, cycles held in GREEN.
- T_AMBER, 1, cycles held in AMBER.
REQ-002 Derived localparam OUT_W SHALL be max(clog2(FACES+1), 3).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- button, input, 1, dice advance request, sampled each clock.
- sel, input, 1, output select: 0 = dice, 1 = traffic lights.
- result, output, OUT_W, registered selected value.
REQ-004 Elaboration SHALL fail on any of: FACES outside 2..255; any T_* < 1; any T_* > 255.

Function
REQ-005 The dice engine and the traffic engine SHALL both advance every clock, independent of sel; sel affects only result.
REQ-006 Dice state dval (OUT_W bits) SHALL take the legal values 1..FACES, with 0 permitted only after reset.
REQ-007 Dice with button=1:
- dval==0, or dval>=FACES: next value 1.
- otherwise: next value dval+1.
REQ-008 Dice with button=0:
- dval in 1..FACES: hold.
- dval==0: hold 0.
- dval>FACES (illegal): force to 1.
REQ-009 Traffic FSM states and encodings {red,amber,green}:
- RED = 100
- RED_AMBER = 110
- GREEN = 001
- AMBER = 010
REQ-010 Traffic transitions SHALL be RED -> RED_AMBER -> GREEN -> AMBER -> RED only.
REQ-011 Each traffic state SHALL be held for exactly its T_* cycles:
- An 8-bit dwell counter is cleared on state entry.
- The state advances on the edge where dwell == T_x-1.
REQ-012 An illegal traffic encoding, if ever reached, SHALL go to RED with dwell 0 on the next edge.
REQ-013 Full cycle period SHALL be T_RED+T_RED_AMBER+T_GREEN+T_AMBER cycles; the default is 10.
REQ-014 result SHALL be registered and updated each edge:
- sel=1: {zeros, next traffic encoding}.
- sel=0: next dval.
- result therefore equals the selected engine's state after the same edge, with zero added latency.
REQ-015 A sel change SHALL take effect on the next edge; neither engine loses or repeats a step across the switch.
REQ-016 result bits above bit 2 SHALL be 0 whenever sel=1.
REQ-017 Simultaneous button and sel change SHALL both apply on the same edge: the dice advances and result shows the newly selected engine.

Reset
REQ-018 rst low SHALL immediately, without waiting for clk:
- set dval=0
- set traffic state to RED with dwell=0
- set result=0
REQ-019 While rst is low, all state SHALL hold the REQ-018 values regardless of button, sel or clk.
REQ-020 Reset deassertion SHALL be synchronised by a 2-flop release synchroniser; the first state update occurs on the 2nd rising edge after rst rises.
REQ-021 The first update after reset SHALL behave as follows:
- Traffic spends its full T_RED in RED counted from that edge.
- Dice goes to 1 on the first sampled button=1.
REQ-022 rst asserted mid-phase SHALL discard the dwell count and the dice value; there is no partial-state retention.

Verification (defaults unless stated)
REQ-023 Dice sequence:
- Stimulus: sel=0, button=1 for 8 cycles after reset release.
- Required result: 1,2,3,4,5,6,1,2.
- Then button=0 for 3 cycles: result holds 2.
REQ-024 Traffic sequence:
- Stimulus: sel=1 held for 20 cycles.
- Required result: 100 x4, 110 x1, 001 x4, 010 x1, repeated twice.
REQ-025 Concurrency:
- Stimulus: sel=0 with button=1 for 5 cycles, then sel=1.
- Required: result equals the traffic state 5 cycles into the cycle, i.e. 110 (RED_AMBER).
- Then sel=0 again: result is 5, not 0.
REQ-026 Asynchronous reset:
- Stimulus: assert rst low mid-GREEN, between clock edges.
- Required: result=0 in the same timestep.
- After release and the 2-edge sync: result=100 with sel=1, held for 4 cycles.
REQ-027 Parameterised build:
- Build: FACES=12, T_GREEN=2.
- Required: OUT_W=4; dice wraps 12->1; traffic period is 8 cycles.
- With sel=1: bit 3 of result stays 0.
REQ-028 Simultaneous events:
- Stimulus: button=1 and sel 1->0 on the same edge with dval=6.
- Required: result=1 on that edge.
